// File: rtl/sargantana_icache_tag_ctrl.sv
// -----------------------------------------------------------------------------
// sargantana_icache_tag_ctrl
//
// Front-end for the instruction-cache tag ways. It places lookups, refill tag
// writes and flushes onto the shared tag-way request bus. It then compares the
// registered tags and valid bits returned by the ways and produces the
// hit / way / multihit / victim response for the miss logic. After reset it
// spends one INIT cycle clearing every way's valid vector.
//
// Ports
//   clk_i, rstn_i             clock, asynchronous active-low reset
//   lookup_valid_i/ready_o    lookup handshake (idx, tag)
//   lookup_idx_i, lookup_tag_i
//   resp_valid_o              one-cycle pulse, two cycles after lookup accept
//   resp_hit_o, resp_way_o    any-way hit, one-hot lowest hitting way
//   resp_multihit_o           more than one way hit
//   resp_victim_o             one-hot replacement way on miss, 0 on hit
//   refill_valid_i/ready_o    refill tag write handshake (way, idx, tag)
//   refill_way_i, refill_idx_i, refill_tag_i
//   flush_i                   invalidate all ways
//   tag_req_o .. tag_data_o   request bus to the tag ways
//   tag_data_i, tag_vbit_i    per-way registered read tag / valid bit
//
// Configuration macro
//   SARGANTANA_ICACHE_RANDOM_REPL_EN  defined: the replacement pointer comes
//                                     from a 16-bit LFSR. Undefined: it is a
//                                     round-robin counter that advances on
//                                     each accepted refill.
// -----------------------------------------------------------------------------
module sargantana_icache_tag_ctrl #(
    parameter int unsigned NUM_WAYS       = 4,
    parameter int unsigned TAG_DEPTH      = 64,
    parameter int unsigned TAG_ADDR_WIDHT = $clog2(TAG_DEPTH),
    parameter int unsigned TAG_WIDHT      = 20
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          lookup_valid_i,
    output logic                          lookup_ready_o,
    input  logic [TAG_ADDR_WIDHT-1:0]     lookup_idx_i,
    input  logic [TAG_WIDHT-1:0]          lookup_tag_i,
    output logic                          resp_valid_o,
    output logic                          resp_hit_o,
    output logic [NUM_WAYS-1:0]           resp_way_o,
    output logic                          resp_multihit_o,
    output logic [NUM_WAYS-1:0]           resp_victim_o,
    input  logic                          refill_valid_i,
    output logic                          refill_ready_o,
    input  logic [NUM_WAYS-1:0]           refill_way_i,
    input  logic [TAG_ADDR_WIDHT-1:0]     refill_idx_i,
    input  logic [TAG_WIDHT-1:0]          refill_tag_i,
    input  logic                          flush_i,
    output logic [NUM_WAYS-1:0]           tag_req_o,
    output logic                          tag_we_o,
    output logic                          tag_vbit_o,
    output logic                          tag_flush_o,
    output logic [TAG_ADDR_WIDHT-1:0]     tag_addr_o,
    output logic [TAG_WIDHT-1:0]          tag_data_o,
    input  logic [NUM_WAYS*TAG_WIDHT-1:0] tag_data_i,
    input  logic [NUM_WAYS-1:0]           tag_vbit_i
);

    localparam int unsigned WAY_IDX_W = $clog2(NUM_WAYS);

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e                 state_q, state_d;
    logic                   s2_valid_q, s2_valid_d;
    logic [TAG_WIDHT-1:0]   s2_tag_q, s2_tag_d;
    logic                   resp_valid_q, resp_valid_d;
    logic                   resp_hit_q, resp_hit_d;
    logic [NUM_WAYS-1:0]    resp_way_q, resp_way_d;
    logic                   resp_multihit_q, resp_multihit_d;
    logic [NUM_WAYS-1:0]    resp_victim_q, resp_victim_d;

    logic                   lookup_fire;
    logic [NUM_WAYS-1:0]    hit_vec, hit_onehot, invalid_vec, first_invalid;
    logic [NUM_WAYS-1:0]    repl_onehot, victim_vec;
    logic [WAY_IDX_W-1:0]   repl_ptr;

    // ---------------- control FSM and tag-bus drive ----------------
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case/if tree can leave a latch behind.
    always_comb begin
        state_d        = state_q;
        lookup_ready_o = 1'b0;
        refill_ready_o = 1'b0;
        tag_req_o      = '0;
        tag_we_o       = 1'b0;
        tag_vbit_o     = 1'b0;
        tag_flush_o    = 1'b0;
        tag_addr_o     = '0;
        tag_data_o     = '0;
        unique case (state_q)
            ST_INIT: begin
                tag_flush_o = 1'b1;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                if (flush_i) begin
                    tag_flush_o = 1'b1;
                end else begin
                    refill_ready_o = 1'b1;
                    if (refill_valid_i) begin
                        tag_req_o  = refill_way_i;
                        tag_we_o   = 1'b1;
                        tag_vbit_o = 1'b1;
                        tag_addr_o = refill_idx_i;
                        tag_data_o = refill_tag_i;
                    end else begin
                        lookup_ready_o = 1'b1;
                        if (lookup_valid_i) begin
                            tag_req_o  = '1;
                            tag_addr_o = lookup_idx_i;
                        end
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    assign lookup_fire = lookup_valid_i && lookup_ready_o;

    // Stage 2 holds the tag while the ways return their registered read data.
    always_comb begin
        s2_valid_d = lookup_fire;
        s2_tag_d   = lookup_fire ? lookup_tag_i : s2_tag_q;
    end

    // ---------------- stage-2 compare ----------------
    always_comb begin
        hit_vec = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit_vec[w] = tag_vbit_i[w] &&
                         (tag_data_i[w*TAG_WIDHT +: TAG_WIDHT] == s2_tag_q);
        end
    end

    // x & -x isolates the lowest set bit.
    assign hit_onehot    = hit_vec & (-hit_vec);
    assign invalid_vec   = ~tag_vbit_i;
    assign first_invalid = invalid_vec & (-invalid_vec);
    assign repl_onehot   = NUM_WAYS'(1) << repl_ptr;
    assign victim_vec    = (|hit_vec)     ? '0 :
                           (|invalid_vec) ? first_invalid : repl_onehot;

    // A flush in the compare cycle squashes the response. Response fields are
    // forced to zero whenever no response is being emitted.
    always_comb begin
        resp_valid_d    = s2_valid_q && !flush_i;
        resp_hit_d      = resp_valid_d && (|hit_vec);
        resp_way_d      = resp_valid_d ? hit_onehot : '0;
        // Clearing the lowest set bit leaves something only if >1 bit was set.
        resp_multihit_d = resp_valid_d && (|(hit_vec & (hit_vec - NUM_WAYS'(1))));
        resp_victim_d   = resp_valid_d ? victim_vec : '0;
    end

    // ---------------- replacement pointer ----------------
`ifdef SARGANTANA_ICACHE_RANDOM_REPL_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        lfsr_fb;

    // Fibonacci LFSR, taps 16,14,13,11.
    assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign lfsr_d   = (state_q == ST_RUN) ? {lfsr_q[14:0], lfsr_fb} : lfsr_q;
    assign repl_ptr = lfsr_q[WAY_IDX_W-1:0];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) lfsr_q <= 16'hACE1;
        else         lfsr_q <= lfsr_d;
    end
`else
    logic [WAY_IDX_W-1:0] rr_q, rr_d;
    logic                 refill_fire;

    // NUM_WAYS is a power of two, so the natural wrap gives mod NUM_WAYS.
    assign refill_fire = refill_valid_i && refill_ready_o;
    assign rr_d        = refill_fire ? rr_q + WAY_IDX_W'(1) : rr_q;
    assign repl_ptr    = rr_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) rr_q <= '0;
        else         rr_q <= rr_d;
    end
`endif

    // ---------------- state registers ----------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q         <= ST_INIT;
            s2_valid_q      <= 1'b0;
            s2_tag_q        <= '0;
            resp_valid_q    <= 1'b0;
            resp_hit_q      <= 1'b0;
            resp_way_q      <= '0;
            resp_multihit_q <= 1'b0;
            resp_victim_q   <= '0;
        end else begin
            state_q         <= state_d;
            s2_valid_q      <= s2_valid_d;
            s2_tag_q        <= s2_tag_d;
            resp_valid_q    <= resp_valid_d;
            resp_hit_q      <= resp_hit_d;
            resp_way_q      <= resp_way_d;
            resp_multihit_q <= resp_multihit_d;
            resp_victim_q   <= resp_victim_d;
        end
    end

    assign resp_valid_o    = resp_valid_q;
    assign resp_hit_o      = resp_hit_q;
    assign resp_way_o      = resp_way_q;
    assign resp_multihit_o = resp_multihit_q;
    assign resp_victim_o   = resp_victim_q;

endmodule

// File: doc/sargantana_icache_tag_ctrl.md
# sargantana_icache_tag_ctrl

Tag-lookup and refill controller directly upstream of the instruction-cache tag way memories (one instance per way, NUM_WAYS total). It sequences lookups, refill tag writes and flushes onto the shared tag-way request bus, then compares the registered tags and valid bits the ways return to produce hit/way/victim information for the icache miss logic. It also issues a post-reset valid-bit clear so the ways start empty.

## Interface
- NUM_WAYS, 4, number of tag ways; power of two, ≥2
- TAG_DEPTH, 64, sets per way
- TAG_ADDR_WIDHT, $clog2(TAG_DEPTH), set index width
- TAG_WIDHT, 20, tag width
- clk_i  in  1  clock; single clock domain
- rstn_i  in  1  reset, asynchronous, active-low
- lookup_valid_i  in  1  lookup request
- lookup_ready_o  out  1  lookup accepted when valid&ready
- lookup_idx_i  in  TAG_ADDR_WIDHT  set index
- lookup_tag_i  in  TAG_WIDHT  tag to compare
- resp_valid_o  out  1  response pulse, one per accepted lookup
- resp_hit_o  out  1  any way hit
- resp_way_o  out  NUM_WAYS  one-hot hitting way, lowest index; 0 on miss
- resp_multihit_o  out  1  more than one way hit (error flag)
- resp_victim_o  out  NUM_WAYS  one-hot replacement way on miss; 0 on hit
- refill_valid_i  in  1  refill tag write request
- refill_ready_o  out  1  refill accepted when valid&ready
- refill_way_i  in  NUM_WAYS  one-hot target way
- refill_idx_i  in  TAG_ADDR_WIDHT  refill set index
- refill_tag_i  in  TAG_WIDHT  refill tag
- flush_i  in  1  invalidate all ways (single-cycle pulse)
- tag_req_o  out  NUM_WAYS  per-way request
- tag_we_o  out  1  write enable, shared
- tag_vbit_o  out  1  valid bit written, shared
- tag_flush_o  out  1  valid-vector clear, shared
- tag_addr_o  out  TAG_ADDR_WIDHT  shared index
- tag_data_o  out  TAG_WIDHT  shared write tag
- tag_data_i  in  NUM_WAYS×TAG_WIDHT  per-way registered read tag
- tag_vbit_i  in  NUM_WAYS  per-way registered valid bit

## Operation
- States: INIT, RUN. Reset enters INIT; INIT lasts exactly one cycle driving tag_flush_o=1, all ready outputs 0; then RUN.
- RUN per-cycle priority: flush_i > refill > lookup.
- flush_i=1: tag_flush_o=1, tag_req_o=0, both readies 0; stage-2 lookup squashed (no resp_valid_o).
- Refill (no flush): refill_ready_o=1, lookup_ready_o=0; tag_req_o=refill_way_i, tag_we_o=1, tag_vbit_o=1, tag_addr_o=refill_idx_i, tag_data_o=refill_tag_i.
- Lookup (no flush, no refill): lookup_ready_o=1; on valid: tag_req_o all ones, tag_we_o=0, idx to tag_addr_o; tag captured into stage 2.
- Idle: tag_req_o=0, tag_we_o=0, tag_flush_o=0.
- Stage 2 compare: hit[w] = tag_vbit_i[w] && tag_data_i[w]==stage-2 tag; resp_way_o = lowest set bit; resp_multihit_o = popcount>1.
- Victim on miss: lowest-index way with tag_vbit_i=0; if all valid, replacement pointer (see Configuration).
- Refill writing an index already in stage 2 does not affect that response (tags read before write).

## Timing
- Lookup accepted cycle T; ways read at T edge; compare in T+1; registered response valid in T+2 for one cycle. Latency 2, throughput 1/cycle.
- Refill write visible to lookups accepted at T+1 onward.
- Flush at T: ways cleared at T edge; lookups accepted from T+1 see all misses.
- All response outputs registered; reset value 0. lookup_ready_o, refill_ready_o, tag_* combinational from state and inputs; INIT values as above.
- Reset mid-operation: stage 2 discarded, no response emitted, INIT re-run.

## Configuration
- SARGANTANA_ICACHE_RANDOM_REPL_EN defined: replacement pointer = low $clog2(NUM_WAYS) bits of 16-bit Fibonacci LFSR (taps 16,14,13,11), seed 16'hACE1, advancing every RUN cycle.
- Undefined: round-robin counter, reset 0, increments mod NUM_WAYS on each accepted refill.

## Test plan
- Reset, then lookup idx 5 tag 0x12345 -> one INIT cycle with tag_flush_o=1, lookup_ready_o=0; resp at T+2: hit=0, victim=4'b0001.
- Refill way 4'b0100 idx 5 tag 0x12345, then lookup same -> hit=1, resp_way_o=4'b0100, resp_victim_o=0.
- Fill idx 9 in all 4 ways, lookup tag miss (round-robin, 4 prior refills) -> victim=4'b0001; after one more refill -> 4'b0010.
- Back-to-back lookups idx 1,2,3 -> three resp_valid_o pulses T+2..T+4, in order.
- flush_i in cycle after a lookup accept -> that response suppressed; subsequent lookup of previously hit tag -> hit=0.
- Refill and lookup valid together -> refill_ready_o=1, lookup_ready_o=0; lookup accepted next cycle and hits.
